fb_write_arbiter: RTL and testbench

Parametrised successor to the single-channel framebuffer writer. Accepts rasterised pixels from `CHANNELS` independent producers, buffers each in its own FIFO, round-robin arbitrates them onto one Avalon-MM write master into HPS SDRAM, and performs burst background fills of the selected back buffer. Adds off-screen pixel clipping with a drop counter.

---
 rtl/fb_write_arbiter_if.sv | 33 +++
 rtl/fb_write_arbiter.sv | 246 ++++++++++++++++++++++++
 tb/tb_fb_write_arbiter.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_write_arbiter_if.sv
// Avalon-MM write master bundle for the framebuffer arbiter.
//
// Handshake: the master raises `write` together with address, burstcount,
// byteenable and writedata. A beat is accepted on a rising clock edge where
// `write` is high and `waitrequest` is low. While `waitrequest` is high the
// master holds every field stable. During a burst, address and burstcount
// stay fixed for all beats, and writedata may change only after an accepted beat.
//
// Signals:
//   address     64-bit word address (29 bits)
//   burstcount  beats in the current burst
//   byteenable  byte lanes of the 64-bit word
//   writedata   64-bit write data
//   write       write request
//   waitrequest slave stall
interface fb_write_arbiter_if;
  logic [28:0] address;
  logic [7:0]  burstcount;
  logic [7:0]  byteenable;
  logic [63:0] writedata;
  logic        write;
  logic        waitrequest;

  modport master (
    output address, burstcount, byteenable, writedata, write,
    input  waitrequest
  );

  modport slave (
    input  address, burstcount, byteenable, writedata, write,
    output waitrequest
  );
endinterface

// File: rtl/fb_write_arbiter.sv
// Multi-channel framebuffer writer.
// Each of CHANNELS pixel producers pushes into its own FIFO. Off-screen pixels
// are dropped and counted. A round-robin arbiter turns queued pixels into
// single-beat Avalon-MM writes. A background fill writes the whole selected
// buffer in BURST_LEN bursts and takes priority over pixels.
//
// Ports:
//   clock, reset          single clock, asynchronous active-high reset
//   avm                   Avalon-MM write master (see fb_write_arbiter_if)
//   buffer                target buffer (0 = FB0_BASE, 1 = FB1_BASE)
//   fill_background       fill request, level-sampled
//   background_colour     fill colour 0x00RRGGBB
//   pixel_data            channel k at [64k+63:64k]: {4'b0,x,4'b0,y,colour}
//   pixel_data_valid      per-channel push strobe
//   pixel_fifo_full       per-channel FIFO full
//   pixel_fifo_empty      all FIFOs empty and FSM idle
//   busy                  FSM not idle
//   dropped_count         clipped pixel count, saturating
//   state                 FSM state code (IDLE=0, ARB=1, PIX_WRITE=2, FILL_BURST=3)
module fb_write_arbiter #(
  parameter int          CHANNELS   = 2,
  parameter int          FIFO_DEPTH = 16,
  parameter int          H_RES      = 640,
  parameter int          V_RES      = 480,
  parameter int          BURST_LEN  = 8,
  parameter logic [28:0] FB0_BASE   = 29'h0F00_0000,
  parameter logic [28:0] FB1_BASE   = 29'h0F04_B000
) (
  input  logic                     clock,
  input  logic                     reset,
  fb_write_arbiter_if.master       avm,
  input  logic                     buffer,
  input  logic                     fill_background,
  input  logic [31:0]              background_colour,
  input  logic [CHANNELS*64-1:0]   pixel_data,
  input  logic [CHANNELS-1:0]      pixel_data_valid,
  output logic [CHANNELS-1:0]      pixel_fifo_full,
  output logic                     pixel_fifo_empty,
  output logic                     busy,
  output logic [15:0]              dropped_count,
  output logic [3:0]               state
);

  localparam int PTR_W       = $clog2(FIFO_DEPTH);
  localparam int CNT_W       = PTR_W + 1;
  localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int TOTAL_WORDS = H_RES * V_RES / 2;
  localparam int WORD_W      = $clog2(TOTAL_WORDS + 1);
  localparam int BEAT_W      = $clog2(BURST_LEN + 1);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    ARB        = 4'd1,
    PIX_WRITE  = 4'd2,
    FILL_BURST = 4'd3
  } state_t;

  state_t state_q, state_d;

  // FIFO entries are stored as {x[11:0], y[11:0], colour[31:0]}.
  logic [55:0]       fifo_mem [CHANNELS][FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr   [CHANNELS];
  logic [PTR_W-1:0]  rd_ptr   [CHANNELS];
  logic [CNT_W-1:0]  fifo_cnt [CHANNELS];

  logic [CHANNELS-1:0] push, drop, pop, non_empty;
  logic [3:0]          drop_sum;
  logic [16:0]         drop_total;
  logic [CH_W-1:0]     rr_ptr, sel_ch;
  logic                sel_found;
  logic [55:0]         head;
  logic [23:0]         pix_idx;
  logic                fill_pending;
  logic [WORD_W-1:0]   word_cnt;
  logic [BEAT_W-1:0]   beat_cnt;
  logic                beat_accept, last_word, last_beat;

  // Push / clip decode. A full FIFO ignores the strobe entirely, so a
  // blocked off-screen pixel is not counted as dropped either.
  always_comb begin
    push      = '0;
    drop      = '0;
    non_empty = '0;
    pixel_fifo_full = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      non_empty[k]       = (fifo_cnt[k] != '0);
      pixel_fifo_full[k] = (fifo_cnt[k] == CNT_W'(FIFO_DEPTH));
      if (pixel_data_valid[k] && !pixel_fifo_full[k]) begin
        if (int'(pixel_data[64*k+48 +: 12]) < H_RES &&
            int'(pixel_data[64*k+32 +: 12]) < V_RES)
          push[k] = 1'b1;
        else
          drop[k] = 1'b1;
      end
    end
  end

  // Several channels may clip in one cycle, so add them all before saturating.
  always_comb begin
    drop_sum = '0;
    for (int k = 0; k < CHANNELS; k++)
      drop_sum = drop_sum + 4'(drop[k]);
    drop_total = {1'b0, dropped_count} + {13'b0, drop_sum};
  end

  // Round-robin pick: first non-empty channel at or after rr_ptr.
  always_comb begin
    sel_found = 1'b0;
    sel_ch    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (!sel_found && non_empty[(int'(rr_ptr) + i) % CHANNELS]) begin
        sel_found = 1'b1;
        sel_ch    = CH_W'((int'(rr_ptr) + i) % CHANNELS);
      end
    end
  end

  always_comb begin
    pop = '0;
    if (state_q == ARB && sel_found)
      pop[sel_ch] = 1'b1;
  end

  assign head    = fifo_mem[sel_ch][rd_ptr[sel_ch]];
  assign pix_idx = 24'(int'(head[43:32]) * H_RES + int'(head[55:44]));

  always_ff @(posedge clock) begin
    for (int k = 0; k < CHANNELS; k++)
      if (push[k])
        fifo_mem[k][wr_ptr[k]] <= {pixel_data[64*k+48 +: 12],
                                   pixel_data[64*k+32 +: 12],
                                   pixel_data[64*k +: 32]};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < CHANNELS; k++) begin
        wr_ptr[k]   <= '0;
        rd_ptr[k]   <= '0;
        fifo_cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (push[k]) wr_ptr[k] <= wr_ptr[k] + 1'b1;
        if (pop[k])  rd_ptr[k] <= rd_ptr[k] + 1'b1;
        if (push[k] && !pop[k])      fifo_cnt[k] <= fifo_cnt[k] + 1'b1;
        else if (pop[k] && !push[k]) fifo_cnt[k] <= fifo_cnt[k] - 1'b1;
      end
    end
  end

  assign beat_accept = avm.write && !avm.waitrequest;
  assign last_word   = (word_cnt == WORD_W'(TOTAL_WORDS - 1));
  assign last_beat   = (beat_cnt == BEAT_W'(BURST_LEN - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (fill_background || fill_pending) state_d = FILL_BURST;
        else if (|non_empty)                 state_d = ARB;
      end
      ARB:        state_d = sel_found ? PIX_WRITE : IDLE;
      PIX_WRITE:  if (!avm.waitrequest) state_d = IDLE;
      FILL_BURST: if (beat_accept && last_word) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Bus registers only move on an accepted beat, which keeps them stable
  // under waitrequest.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      avm.write      <= 1'b0;
      avm.address    <= '0;
      avm.burstcount <= 8'd1;
      avm.byteenable <= '0;
      avm.writedata  <= '0;
      rr_ptr         <= '0;
      fill_pending   <= 1'b0;
      word_cnt       <= '0;
      beat_cnt       <= '0;
      dropped_count  <= '0;
    end else begin
      dropped_count <= drop_total[16] ? 16'hFFFF : drop_total[15:0];

      if (state_q == FILL_BURST && beat_accept && last_word)
        fill_pending <= 1'b0;
      else if (fill_background && state_q != IDLE)
        fill_pending <= 1'b1;

      case (state_q)
        IDLE: begin
          if (state_d == FILL_BURST) begin
            avm.address    <= buffer ? FB1_BASE : FB0_BASE;
            avm.burstcount <= 8'(BURST_LEN);
            avm.byteenable <= 8'hFF;
            avm.writedata  <= {background_colour, background_colour};
            avm.write      <= 1'b1;
            word_cnt       <= '0;
            beat_cnt       <= '0;
          end
        end
        ARB: begin
          if (sel_found) begin
            avm.address    <= (buffer ? FB1_BASE : FB0_BASE) + 29'(pix_idx[23:1]);
            avm.burstcount <= 8'd1;
            avm.byteenable <= pix_idx[0] ? 8'hF0 : 8'h0F;
            avm.writedata  <= {head[31:0], head[31:0]};
            avm.write      <= 1'b1;
            rr_ptr         <= (sel_ch == CH_W'(CHANNELS - 1)) ? '0 : sel_ch + 1'b1;
          end
        end
        PIX_WRITE: begin
          if (!avm.waitrequest) avm.write <= 1'b0;
        end
        FILL_BURST: begin
          if (beat_accept) begin
            word_cnt <= word_cnt + 1'b1;
            if (last_word) begin
              avm.write <= 1'b0;
            end else if (last_beat) begin
              // Next burst starts immediately on the following cycle.
              beat_cnt      <= '0;
              avm.address   <= avm.address + 29'(BURST_LEN);
              avm.writedata <= {background_colour, background_colour};
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign state            = state_q;
  assign busy             = (state_q != IDLE);
  assign pixel_fifo_empty = ~|non_empty && (state_q == IDLE);

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter. dut_a uses the 640x480 defaults;
// dut_b uses a 16x4 framebuffer so whole fills stay short.
module tb_fb_write_arbiter;
  localparam int W = 109;  // {address, burstcount, byteenable, writedata}
  localparam logic [28:0] FB0 = 29'h0F00_0000;
  localparam logic [28:0] FB1 = 29'h0F04_B000;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  fb_write_arbiter_if avm_a ();
  fb_write_arbiter_if avm_b ();

  logic         buffer_a = 0, fill_a = 0, buffer_b = 0, fill_b = 0;
  logic [31:0]  bg_a = 0, bg_b = 0;
  logic [127:0] pix_a = 0, pix_b = 0;
  logic [1:0]   val_a = 0, val_b = 0;
  logic [1:0]   full_a, full_b;
  logic         empty_a, empty_b, busy_a, busy_b;
  logic [15:0]  drop_a, drop_b;
  logic [3:0]   state_a, state_b;

  fb_write_arbiter dut_a (
    .clock(clock), .reset(reset), .avm(avm_a),
    .buffer(buffer_a), .fill_background(fill_a), .background_colour(bg_a),
    .pixel_data(pix_a), .pixel_data_valid(val_a), .pixel_fifo_full(full_a),
    .pixel_fifo_empty(empty_a), .busy(busy_a), .dropped_count(drop_a),
    .state(state_a)
  );

  fb_write_arbiter #(.H_RES(16), .V_RES(4)) dut_b (
    .clock(clock), .reset(reset), .avm(avm_b),
    .buffer(buffer_b), .fill_background(fill_b), .background_colour(bg_b),
    .pixel_data(pix_b), .pixel_data_valid(val_b), .pixel_fifo_full(full_b),
    .pixel_fifo_empty(empty_b), .busy(busy_b), .dropped_count(drop_b),
    .state(state_b)
  );

  initial begin
    avm_a.waitrequest = 1'b0;
    avm_b.waitrequest = 1'b0;
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] got_a[$];
  logic [W-1:0] got_b[$];
  logic [W-1:0] exp_q[$];

  always @(negedge clock) begin
    if (!reset && avm_a.write && !avm_a.waitrequest)
      got_a.push_back({avm_a.address, avm_a.burstcount, avm_a.byteenable, avm_a.writedata});
    if (!reset && avm_b.write && !avm_b.waitrequest)
      got_b.push_back({avm_b.address, avm_b.burstcount, avm_b.byteenable, avm_b.writedata});
  end

  // Stalled beats on dut_b must present identical fields on the next cycle.
  logic         hold_vld = 1'b0;
  logic [W-1:0] hold_val;
  always @(negedge clock) begin
    if (reset) begin
      hold_vld = 1'b0;
    end else begin
      if (hold_vld && avm_b.write) begin
        total++;
        if ({avm_b.address, avm_b.burstcount, avm_b.byteenable, avm_b.writedata} !== hold_val) begin
          bad++;
          $display("FAIL stall_stable got=%h exp=%h",
                   {avm_b.address, avm_b.burstcount, avm_b.byteenable, avm_b.writedata}, hold_val);
        end
      end
      hold_vld = avm_b.write && avm_b.waitrequest;
      hold_val = {avm_b.address, avm_b.burstcount, avm_b.byteenable, avm_b.writedata};
    end
  end

  // ---------------- driver helpers ----------------
  function automatic logic [63:0] mk_pix(input int x, input int y, input logic [31:0] c);
    return {4'b0, x[11:0], 4'b0, y[11:0], c};
  endfunction

  task automatic do_reset();
    val_a = 0; val_b = 0; fill_a = 0; fill_b = 0;
    avm_a.waitrequest = 0; avm_b.waitrequest = 0;
    reset = 1;
    repeat (3) @(posedge clock);
    #1 reset = 0;
    got_a.delete(); got_b.delete(); exp_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    total++;
    if ({avm_a.write, avm_a.address, avm_a.burstcount, avm_a.byteenable, avm_a.writedata}
        !== {1'b0, 29'h0, 8'd1, 8'h00, 64'h0}) begin
      bad++;
      $display("FAIL reset_bus got=%h", {avm_a.write, avm_a.address, avm_a.burstcount,
                                        avm_a.byteenable, avm_a.writedata});
    end
    total++;
    if ({full_a, empty_a, busy_a, state_a, drop_a} !== {2'b00, 1'b1, 1'b0, 4'd0, 16'd0}) begin
      bad++;
      $display("FAIL reset_status got=%h exp=%h", {full_a, empty_a, busy_a, state_a, drop_a},
               {2'b00, 1'b1, 1'b0, 4'd0, 16'd0});
    end
    total++;
    if ({avm_b.write, avm_b.burstcount, empty_b, state_b} !== {1'b0, 8'd1, 1'b1, 4'd0}) begin
      bad++;
      $display("FAIL reset_b got=%h", {avm_b.write, avm_b.burstcount, empty_b, state_b});
    end
  endtask

  task automatic test_single_pixel();
    int first;
    do_reset();
    buffer_a = 0;
    first = -1;
    @(posedge clock); #1;
    pix_a = {64'h0, mk_pix(3, 2, 32'h00FF0000)};
    val_a = 2'b01;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clock); #1;
      if (k == 1) val_a = 0;
      if (avm_a.write && first < 0) first = k;
    end
    total++;
    if (first != 3) begin
      bad++;
      $display("FAIL pixel_latency got=%0d exp=3", first);
    end
    exp_q.push_back({FB0 + 29'd641, 8'd1, 8'hF0, 64'h00FF0000_00FF0000});
    total++;
    if (got_a.size() != 1) begin
      bad++;
      $display("FAIL pixel_count got=%0d exp=1", got_a.size());
    end else if (got_a[0] !== exp_q[0]) begin
      bad++;
      $display("FAIL pixel_write got=%h exp=%h", got_a[0], exp_q[0]);
    end
  endtask

  task automatic test_round_robin();
    logic [28:0] offs [6];
    logic [7:0]  bes  [6];
    logic [31:0] cols [6];
    int c;
    offs = '{29'd5, 29'd330, 29'd5, 29'd330, 29'd6, 29'd331};
    bes  = '{8'h0F, 8'h0F, 8'hF0, 8'hF0, 8'h0F, 8'h0F};
    cols = '{32'h00A00000, 32'h00B00000, 32'h00A00001, 32'h00B00001, 32'h00A00002, 32'h00B00002};
    do_reset();
    buffer_a = 0;
    @(posedge clock); #1;
    for (int i = 0; i < 3; i++) begin
      pix_a = {mk_pix(20 + i, 1, 32'h00B00000 + 32'(i)), mk_pix(10 + i, 0, 32'h00A00000 + 32'(i))};
      val_a = 2'b11;
      @(posedge clock); #1;
    end
    val_a = 0;
    c = 0;
    while (got_a.size() < 6 && c < 200) begin
      @(posedge clock); #1; c++;
    end
    repeat (2) @(posedge clock);
    #1;
    total++;
    if (got_a.size() != 6) begin
      bad++;
      $display("FAIL rr_count got=%0d exp=6", got_a.size());
    end
    for (int i = 0; i < 6; i++) exp_q.push_back({FB0 + offs[i], 8'd1, bes[i], {cols[i], cols[i]}});
    for (int i = 0; i < 6 && i < got_a.size(); i++) begin
      total++;
      if (got_a[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL rr_write%0d got=%h exp=%h", i, got_a[i], exp_q[i]);
      end
    end
    total++;
    if (empty_a !== 1'b1) begin
      bad++;
      $display("FAIL rr_empty got=%b exp=1", empty_a);
    end
  endtask

  task automatic test_fill();
    int c;
    do_reset();
    buffer_b = 1;
    bg_b = 32'h000000FF;
    @(posedge clock); #1 fill_b = 1;
    @(posedge clock); #1 fill_b = 0;
    c = 0;
    while (got_b.size() < 32 && c < 2000) begin
      avm_b.waitrequest = 1'($urandom_range(0, 1));
      @(posedge clock); #1; c++;
    end
    avm_b.waitrequest = 0;
    repeat (10) @(posedge clock);
    #1;
    total++;
    if (got_b.size() != 32) begin
      bad++;
      $display("FAIL fill_count got=%0d exp=32", got_b.size());
    end
    for (int j = 0; j < 32; j++)
      exp_q.push_back({FB1 + 29'((j / 8) * 8), 8'd8, 8'hFF, 64'h000000FF_000000FF});
    for (int j = 0; j < 32 && j < got_b.size(); j++) begin
      total++;
      if (got_b[j] !== exp_q[j]) begin
        bad++;
        $display("FAIL fill_beat%0d got=%h exp=%h", j, got_b[j], exp_q[j]);
      end
    end
    total++;
    if ({busy_b, state_b} !== {1'b0, 4'd0}) begin
      bad++;
      $display("FAIL fill_idle got=%h exp=0", {busy_b, state_b});
    end
  endtask

  task automatic test_clipping();
    do_reset();
    buffer_a = 0;
    @(posedge clock); #1;
    pix_a = {64'h0, mk_pix(640, 0, 32'h1)};  val_a = 2'b01;
    @(posedge clock); #1;
    pix_a = {64'h0, mk_pix(0, 480, 32'h2)};  val_a = 2'b01;
    @(posedge clock); #1;
    pix_a = {64'h0, mk_pix(639, 479, 32'h00010203)}; val_a = 2'b01;
    @(posedge clock); #1;
    val_a = 0;
    repeat (10) @(posedge clock);
    #1;
    total++;
    if (drop_a !== 16'd2) begin
      bad++;
      $display("FAIL clip_count got=%0d exp=2", drop_a);
    end
    exp_q.push_back({29'h0F0257FF, 8'd1, 8'hF0, 64'h00010203_00010203});
    total++;
    if (got_a.size() != 1) begin
      bad++;
      $display("FAIL clip_writes got=%0d exp=1", got_a.size());
    end else if (got_a[0] !== exp_q[0]) begin
      bad++;
      $display("FAIL clip_edge_pixel got=%h exp=%h", got_a[0], exp_q[0]);
    end
    pix_a = {mk_pix(700, 0, 32'h0), mk_pix(0, 700, 32'h0)};
    val_a = 2'b11;
    repeat (10) @(posedge clock);
    #1;
    total++;
    if (drop_a !== 16'd22) begin
      bad++;
      $display("FAIL clip_dual got=%0d exp=22", drop_a);
    end
    repeat (34990) @(posedge clock);
    #1;
    val_a = 0;
    @(posedge clock); #1;
    total++;
    if (drop_a !== 16'hFFFF) begin
      bad++;
      $display("FAIL clip_saturate got=%h exp=ffff", drop_a);
    end
    total++;
    if (got_a.size() != 1) begin
      bad++;
      $display("FAIL clip_no_writes got=%0d exp=1", got_a.size());
    end
  endtask

  task automatic test_full_fifo();
    int c;
    do_reset();
    buffer_a = 0;
    avm_a.waitrequest = 1;
    // A ch1 pixel parks the master in a stalled write so ch0 is never popped.
    @(posedge clock); #1;
    pix_a = {mk_pix(1, 7, 32'h00C0FFEE), 64'h0}; val_a = 2'b10;
    @(posedge clock); #1;
    val_a = 0;
    c = 0;
    while (!avm_a.write && c < 20) begin
      @(posedge clock); #1; c++;
    end
    total++;
    if (avm_a.write !== 1'b1) begin
      bad++;
      $display("FAIL full_blocker got=%b exp=1", avm_a.write);
    end
    for (int i = 0; i < 20; i++) begin
      pix_a = {64'h0, mk_pix(i, 5, 32'(i))};
      val_a = 2'b01;
      @(posedge clock); #1;
      if (i == 14) begin
        total++;
        if (full_a[0] !== 1'b0) begin
          bad++;
          $display("FAIL full_early got=%b exp=0", full_a[0]);
        end
      end
      if (i == 15 || i == 19) begin
        total++;
        if (full_a[0] !== 1'b1) begin
          bad++;
          $display("FAIL full_flag%0d got=%b exp=1", i, full_a[0]);
        end
      end
    end
    val_a = 0;
    avm_a.waitrequest = 0;
    c = 0;
    while (got_a.size() < 17 && c < 300) begin
      @(posedge clock); #1; c++;
    end
    repeat (20) @(posedge clock);
    #1;
    exp_q.push_back({FB0 + 29'd2240, 8'd1, 8'hF0, 64'h00C0FFEE_00C0FFEE});
    for (int i = 0; i < 16; i++)
      exp_q.push_back({FB0 + 29'((3200 + i) / 2), 8'd1, (i % 2 == 1) ? 8'hF0 : 8'h0F,
                       {32'(i), 32'(i)}});
    total++;
    if (got_a.size() != 17) begin
      bad++;
      $display("FAIL full_count got=%0d exp=17", got_a.size());
    end
    for (int i = 0; i < 17 && i < got_a.size(); i++) begin
      total++;
      if (got_a[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL full_write%0d got=%h exp=%h", i, got_a[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_fill_vs_pixels();
    int c, n;
    do_reset();
    buffer_b = 0;
    bg_b = 32'h00123456;
    avm_b.waitrequest = 1;
    @(posedge clock); #1;
    for (int i = 0; i < 3; i++) begin
      pix_b = {64'h0, mk_pix(1 + i, 2, 32'h00E00000 + 32'(i))};
      val_b = 2'b01;
      @(posedge clock); #1;
    end
    val_b = 0;
    c = 0;
    while (!avm_b.write && c < 20) begin
      @(posedge clock); #1; c++;
    end
    fill_b = 1;
    @(posedge clock); #1 fill_b = 0;
    repeat (2) @(posedge clock);
    #1 avm_b.waitrequest = 0;
    c = 0;
    while (got_b.size() < 35 && c < 500) begin
      @(posedge clock); #1; c++;
    end
    repeat (5) @(posedge clock);
    #1;
    exp_q.push_back({FB0 + 29'd16, 8'd1, 8'hF0, 64'h00E00000_00E00000});
    for (int j = 0; j < 32; j++)
      exp_q.push_back({FB0 + 29'((j / 8) * 8), 8'd8, 8'hFF, 64'h00123456_00123456});
    exp_q.push_back({FB0 + 29'd17, 8'd1, 8'h0F, 64'h00E00001_00E00001});
    exp_q.push_back({FB0 + 29'd17, 8'd1, 8'hF0, 64'h00E00002_00E00002});
    total++;
    if (got_b.size() != 35) begin
      bad++;
      $display("FAIL prio_count got=%0d exp=35", got_b.size());
    end
    for (int j = 0; j < 35 && j < got_b.size(); j++) begin
      total++;
      if (got_b[j] !== exp_q[j]) begin
        bad++;
        $display("FAIL prio_write%0d got=%h exp=%h", j, got_b[j], exp_q[j]);
      end
    end
    total++;
    if (empty_b !== 1'b1) begin
      bad++;
      $display("FAIL prio_empty got=%b exp=1", empty_b);
    end

    // Reset in the middle of a second fill.
    got_b.delete();
    fill_b = 1;
    @(posedge clock); #1 fill_b = 0;
    repeat (12) @(posedge clock);
    #1 reset = 1;
    n = got_b.size();
    @(posedge clock); #1;
    total++;
    if ({avm_b.write, state_b} !== {1'b0, 4'd0}) begin
      bad++;
      $display("FAIL reset_mid_fill got=%h exp=0", {avm_b.write, state_b});
    end
    total++;
    if (n < 1 || n > 31) begin
      bad++;
      $display("FAIL partial_fill got=%0d exp=1..31", n);
    end
    reset = 0;
    repeat (20) @(posedge clock);
    #1;
    total++;
    if (got_b.size() != n || avm_b.write !== 1'b0) begin
      bad++;
      $display("FAIL fill_not_resumed got=%0d exp=%0d", got_b.size(), n);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_single_pixel();
    test_round_robin();
    test_fill();
    test_clipping();
    test_full_fifo();
    test_fill_vs_pixels();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
